// File: rtl/seq_const_alu.sv
// Registered constant-operand ALU with a writable constant bank, accumulate mode,
// a valid/ready start handshake and multi-cycle shift-add multiply / iterative shift.
module seq_const_alu #(
    parameter int WIDTH  = 8,
    parameter int CSEL_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  MyInput,
    input  logic [CSEL_W-1:0] MyConstantSelect,
    input  logic [2:0]        MyOperation,
    input  logic              MyAccumulate,
    input  logic              MyStart,
    input  logic              MyConstWrite,
    output logic              MyReady,
    output logic              MyDone,
    output logic [WIDTH-1:0]  MyOutput,
    output logic              MyStatus,
    output logic              MyZero
);

    localparam int NCONST = 1 << CSEL_W;
    localparam int SH_W   = $clog2(WIDTH);
    localparam int CNT_W  = SH_W + 1;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_SHL  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Returns {status, result} for every operation that completes at the accept edge.
    function automatic logic [WIDTH:0] alu_single(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_NOR:  r = {1'b0, ~(a | b)};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  work_q, work_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                status_q, status_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    const_q [NCONST];
    logic [WIDTH-1:0]    const_d [NCONST];

    logic [WIDTH-1:0]    opa;
    logic [WIDTH-1:0]    opb;
    logic [SH_W-1:0]     shamt;
    logic [2*WIDTH-1:0]  acc_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        out_d    = out_q;
        status_d = status_q;
        done_d   = 1'b0;
        const_d  = const_q;
        opa      = MyAccumulate ? out_q : MyInput;
        opb      = const_q[MyConstantSelect];
        shamt    = opb[SH_W-1:0];
        acc_nx   = acc_q;

        case (state_q)
            S_IDLE: begin
                // The operation reads const_q, so a coincident write is seen only by later ops.
                if (MyConstWrite) begin
                    const_d[MyConstantSelect] = MyInput;
                end
                if (MyStart) begin
                    if (MyOperation == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = CNT_W'(WIDTH);
                        work_d   = {{WIDTH{1'b0}}, opa};
                        mplier_d = opb;
                        acc_d    = '0;
                    end else if (MyOperation == OP_SHL && shamt != '0) begin
                        state_d = S_SHIFT;
                        cnt_d   = {1'b0, shamt};
                        work_d  = {{WIDTH{1'b0}}, opa};
                    end else begin
                        {status_d, out_d} = alu_single(MyOperation, opa, opb);
                        done_d            = 1'b1;
                    end
                end
            end

            S_MUL: begin
                acc_nx   = mplier_q[0] ? (acc_q + work_q) : acc_q;
                acc_d    = acc_nx;
                work_d   = work_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d    = acc_nx[WIDTH-1:0];
                    status_d = |acc_nx[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            S_SHIFT: begin
                work_d = work_q << 1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d    = work_d[WIDTH-1:0];
                    status_d = work_q[WIDTH-1];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
            status_q <= 1'b0;
            done_q   <= 1'b0;
            for (int k = 0; k < NCONST; k++) begin
                const_q[k] <= WIDTH'(2 * k + 1);
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            status_q <= status_d;
            done_q   <= done_d;
            const_q  <= const_d;
        end
    end

    // Working datapath registers are always reloaded at accept, so they need no reset.
    always_ff @(posedge clk) begin
        work_q   <= work_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
    end

    assign MyReady  = (state_q == S_IDLE);
    assign MyDone   = done_q;
    assign MyOutput = out_q;
    assign MyStatus = status_q;
    assign MyZero   = (out_q == '0);

endmodule

// File: tb/tb_seq_const_alu.sv
// Randomized self-checking bench for seq_const_alu against a transaction-level reference model.
module tb_seq_const_alu;

    logic       clk;
    logic       reset_n;
    logic [7:0] MyInput;
    logic [1:0] MyConstantSelect;
    logic [2:0] MyOperation;
    logic       MyAccumulate;
    logic       MyStart;
    logic       MyConstWrite;
    logic       MyReady;
    logic       MyDone;
    logic [7:0] MyOutput;
    logic       MyStatus;
    logic       MyZero;

    int n_chk;
    int n_pass;

    int   mconst [4];
    logic [7:0] m_out;

    seq_const_alu #(.WIDTH(8), .CSEL_W(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .MyInput          (MyInput),
        .MyConstantSelect (MyConstantSelect),
        .MyOperation      (MyOperation),
        .MyAccumulate     (MyAccumulate),
        .MyStart          (MyStart),
        .MyConstWrite     (MyConstWrite),
        .MyReady          (MyReady),
        .MyDone           (MyDone),
        .MyOutput         (MyOutput),
        .MyStatus         (MyStatus),
        .MyZero           (MyZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) mconst[k] = 2 * k + 1;
        m_out = 8'h00;
    endfunction

    // Plain-arithmetic reference: result, status and busy cycles (0 = single cycle).
    function automatic void calc(input int op, input int a, input int b,
                                 output int r, output int st, output int lat);
        int t;
        int s;
        st  = 0;
        lat = 0;
        case (op)
            0: r = a;
            1: begin t = a + b; r = t % 256; st = (t > 255) ? 1 : 0; end
            2: begin r = (a - b + 256) % 256; st = (a < b) ? 1 : 0; end
            3: r = 255 - (a | b);
            4: r = a ^ b;
            5: r = a & b;
            6: begin t = a * b; r = t % 256; st = (t / 256 != 0) ? 1 : 0; lat = 8; end
            default: begin
                s   = b % 8;
                r   = (a * (1 << s)) % 256;
                st  = (s == 0) ? 0 : ((a >> (8 - s)) & 1);
                lat = s;
            end
        endcase
    endfunction

    task automatic run_op(input logic [7:0] a, input int sel_i, input int op_i,
                          input bit accum, input bit cw);
        int aa, b, r, st, lat, busy;
        logic [1:0] sel2;
        logic [2:0] op3;
        aa = accum ? int'(m_out) : int'(a);
        b  = mconst[sel_i];
        calc(op_i, aa, b, r, st, lat);
        if (cw) mconst[sel_i] = int'(a);
        sel2 = sel_i[1:0];
        op3  = op_i[2:0];
        MyInput          = a;
        MyConstantSelect = sel2;
        MyOperation      = op3;
        MyAccumulate     = accum;
        MyConstWrite     = cw;
        MyStart          = 1'b1;
        chk("ready_before_accept", {31'd0, MyReady}, 32'd1);
        @(posedge clk); #1;
        MyStart      = 1'b0;
        MyConstWrite = 1'b0;
        busy = 0;
        while (MyReady !== 1'b1 && busy < 64) begin
            chk("done_while_busy", {31'd0, MyDone}, 32'd0);
            MyInput          = 8'($urandom);
            MyConstantSelect = 2'($urandom);
            MyOperation      = 3'($urandom);
            MyAccumulate     = 1'($urandom);
            MyStart          = 1'($urandom);
            MyConstWrite     = 1'($urandom);
            busy++;
            @(posedge clk); #1;
        end
        MyStart      = 1'b0;
        MyConstWrite = 1'b0;
        MyAccumulate = 1'b0;
        chk("busy_cycles", busy, lat);
        chk("done", {31'd0, MyDone}, 32'd1);
        chk("out", {24'd0, MyOutput}, r);
        chk("status", {31'd0, MyStatus}, st);
        chk("zero", {31'd0, MyZero}, (r == 0) ? 32'd1 : 32'd0);
        m_out = r[7:0];
    endtask

    task automatic idle_chk();
        MyStart      = 1'b0;
        MyConstWrite = 1'b0;
        @(posedge clk); #1;
        chk("done_single_pulse", {31'd0, MyDone}, 32'd0);
        chk("out_hold", {24'd0, MyOutput}, {24'd0, m_out});
    endtask

    task automatic const_write(input logic [7:0] v, input int sel_i);
        MyInput          = v;
        MyConstantSelect = sel_i[1:0];
        MyConstWrite     = 1'b1;
        MyStart          = 1'b0;
        @(posedge clk); #1;
        MyConstWrite = 1'b0;
        mconst[sel_i] = int'(v);
        chk("done_after_write", {31'd0, MyDone}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset_n          = 1'b0;
        MyInput          = 8'h00;
        MyConstantSelect = 2'd0;
        MyOperation      = 3'd0;
        MyAccumulate     = 1'b0;
        MyStart          = 1'b0;
        MyConstWrite     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, MyReady}, 32'd1);
        chk("rst_done", {31'd0, MyDone}, 32'd0);
        chk("rst_out", {24'd0, MyOutput}, 32'd0);
        chk("rst_status", {31'd0, MyStatus}, 32'd0);
        chk("rst_zero", {31'd0, MyZero}, 32'd1);
        reset_n = 1'b1;

        // Directed sequence from the block's intended use.
        run_op(8'h02, 1, 4, 1'b0, 1'b0);
        idle_chk();
        run_op(8'hFE, 1, 1, 1'b0, 1'b0);
        run_op(8'h00, 1, 1, 1'b1, 1'b0);
        run_op(8'h02, 1, 2, 1'b0, 1'b0);
        run_op(8'h02, 1, 3, 1'b0, 1'b0);
        const_write(8'h10, 2);
        run_op(8'h15, 2, 6, 1'b0, 1'b0);
        idle_chk();
        run_op(8'h81, 3, 7, 1'b0, 1'b0);
        const_write(8'h08, 0);
        run_op(8'h5A, 0, 7, 1'b0, 1'b0);
        run_op(8'h01, 1, 1, 1'b0, 1'b1);
        run_op(8'h01, 1, 1, 1'b0, 1'b0);

        // Reset in the fourth busy cycle of a multiply.
        MyInput          = 8'h15;
        MyConstantSelect = 2'd2;
        MyOperation      = 3'd6;
        MyStart          = 1'b1;
        @(posedge clk); #1;
        MyStart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        chk("midrst_ready", {31'd0, MyReady}, 32'd1);
        chk("midrst_out", {24'd0, MyOutput}, 32'd0);
        chk("midrst_zero", {31'd0, MyZero}, 32'd1);
        chk("midrst_status", {31'd0, MyStatus}, 32'd0);
        chk("midrst_done", {31'd0, MyDone}, 32'd0);
        idle_chk();
        run_op(8'h00, 1, 1, 1'b0, 1'b0);

        // Randomized traffic with back-to-back accepts and occasional idle/write cycles.
        for (int i = 0; i < 250; i++) begin
            run_op(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) idle_chk();
            if ($urandom_range(0, 9) == 0)
                const_write(8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
